data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder end of the load/store data-memory interface driven by the control unit's datamem_en / rw / size outputs.
- Accepts one LDR/STR request at a time and holds it for a fixed, parameterised access latency.
- Performs a byte or word access on internal byte-addressed, big-endian storage.
- Returns a one-cycle done pulse with read data or an error flag.
- Sits between the execute stage and the memory stage of the datapath.

Parameters:
DEPTH, 256, storage size in bytes; must be a multiple of 4, minimum 4.
LATENCY, 2, cycles from request acceptance to done; minimum 1.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
datamem_en  input  1  request strobe; 1 = access requested.
rw  input  1  1 = read (LDR), 0 = write (STR).
size  input  1  1 = byte, 0 = word.
addr  input  32  byte address.
wdata  input  32  store data; byte stores use wdata[7:0].
busy  output  1  request in flight; high from the acceptance edge until done falls.
done  output  1  one-cycle completion pulse.
rdata  output  32  load result; valid only while done=1, otherwise 0.
err  output  1  valid only with done; 1 = misaligned or out-of-range access.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; busy, done, err = 0; rdata = 0; latency counter = 0.
  - Any pending write is discarded.
  - Storage contents are not cleared.
- States:
  - IDLE -> WAIT: on a rising edge with datamem_en=1. Latch addr, rw, size and wdata; busy=1; counter loads LATENCY-1.
  - WAIT: counter decrements each edge. At the edge where counter==0, go to RESP.
  - RESP: done=1 and busy=1 for exactly one cycle. The next edge returns to IDLE with busy=0 and done=0.
- Input sampling:
  - datamem_en is sampled only in IDLE; inputs in WAIT and RESP are ignored.
  - A requester that holds datamem_en high through RESP gets a new request accepted on the first edge back in IDLE. This is legal back-to-back issue.
- Latency: request sampled at edge T0; done is high in the cycle following edge T0+LATENCY.
- Error check, evaluated on the latched request:
  - Word access with addr[1:0] != 0 -> err.
  - Word access with addr+3 >= DEPTH -> err.
  - Byte access with addr >= DEPTH -> err.
  - Comparisons use full 32-bit addr; no wrap-around.
- On error: err=1 with done, rdata=0, storage unchanged.
- Write commit: non-error writes update storage at the edge entering RESP.
  - Word: byte[a] = wdata[31:24], byte[a+1] = wdata[23:16], byte[a+2] = wdata[15:8], byte[a+3] = wdata[7:0] (big-endian).
  - Byte: byte[a] = wdata[7:0].
- Read data: captured at the edge entering RESP, so it reflects all prior committed writes.
  - Word: {byte[a], byte[a+1], byte[a+2], byte[a+3]}.
  - Byte: zero-extended {24'b0, byte[a]}.
- rdata is 0 for writes.
- Reset mid-operation (WAIT or RESP): the request is abandoned, no write occurs, no done is produced.

Decomposition:
- Shared package holds:
  - SIZE_WORD=1'b0, SIZE_BYTE=1'b1, RW_READ=1'b1, RW_WRITE=1'b0.
  - State encoding: ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2.
- The control unit uses the same size/rw constants.
- One sub-module, data_mem_array:
  - Byte-addressed storage with a single port.
  - Word/byte read and write, big-endian lane mapping, no reset on contents.
- The responder keeps the FSM, counter, latches and error check.

Test Plan:
1. Word write addr=0x10, wdata=0xDEADBEEF, then word read addr=0x10 -> done exactly 2 cycles after acceptance (LATENCY=2), rdata=0xDEADBEEF, err=0, busy drops the cycle after done.
2. Byte read addr=0x11 after scenario 1 -> rdata=0x000000AD. Byte write addr=0x12, wdata=0xFFFFFF55, then word read addr=0x10 -> rdata=0xDEAD55EF.
3. Word read addr=0x13 -> err=1, rdata=0. Word write addr=0xFE -> err=1, and a later word read at 0xFC shows the contents unchanged.
4. Boundary, DEPTH=256: word read 0xFC -> err=0; byte read 0xFF -> err=0; byte read 0x100 -> err=1; word read 0xFFFFFFFC -> err=1 (no wrap).
5. Hold datamem_en=1 continuously with a word read of 0x10 -> done pulses every LATENCY+2 cycles; inputs changed during WAIT do not alter the in-flight rdata.
6. Word write addr=0x20, wdata=0x12345678; assert rst_n=0 during WAIT -> busy=done=0 immediately, and a subsequent word read of 0x20 returns the value stored before the write.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory request interface and responder FSM.
// Includes the access legality rule used on a latched request.
package data_mem_responder_pkg;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;
  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // 33-bit compare so addresses near 2^32 never wrap into range.
  function automatic logic access_err(input logic sz, input logic [31:0] a,
                                      input int unsigned depth);
    logic [32:0] last;
    logic        bad;
    if (sz == SIZE_WORD) begin
      last = {1'b0, a} + 33'd3;
      bad  = (a[1:0] != 2'b00) || (last >= 33'(depth));
    end else begin
      last = {1'b0, a};
      bad  = (last >= 33'(depth));
    end
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port byte-addressed storage with big-endian word lanes.
// Contents are deliberately not reset.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     size,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] base;

  assign base = {1'b0, idx};

  // Out-of-range lanes read as zero; only reachable for rejected requests.
  function automatic logic [7:0] rd_byte(input logic [AW:0] i);
    logic [7:0] b;
    if (i < (AW+1)'(DEPTH)) begin
      b = mem[i[AW-1:0]];
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  // Combinational read mux: zero-extended byte or big-endian word.
  always_comb begin
    rdata = 32'h0000_0000;
    if (size == SIZE_BYTE) begin
      rdata = {24'h00_0000, rd_byte(base)};
    end else begin
      rdata = {rd_byte(base), rd_byte(base + (AW+1)'(1)),
               rd_byte(base + (AW+1)'(2)), rd_byte(base + (AW+1)'(3))};
    end
  end

  // Write port; the responder only enables it for legal requests.
  always_ff @(posedge clk) begin
    if (we) begin
      if (size == SIZE_BYTE) begin
        mem[idx] <= wdata[7:0];
      end else begin
        mem[idx]           <= wdata[31:24];
        mem[idx + AW'(1)]  <= wdata[23:16];
        mem[idx + AW'(2)]  <= wdata[15:8];
        mem[idx + AW'(3)]  <= wdata[7:0];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits LATENCY cycles, then
// commits/reads storage and returns a one-cycle done pulse with data or err.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        datamem_en,
  input  logic        rw,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rw_q;
  logic          size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          req_err;
  logic          commit;
  logic          we;
  logic [31:0]   arr_rdata;

  // Completion edge qualifiers derived from the latched request.
  always_comb begin
    req_err = access_err(size_q, addr_q, DEPTH);
    commit  = (state == ST_WAIT) && (cnt == {CW{1'b0}});
    we      = commit && (rw_q == RW_WRITE) && !req_err;
  end

  data_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .size  (size_q),
    .idx   (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Request FSM with latched request fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= {CW{1'b0}};
      rw_q    <= RW_READ;
      size_q  <= SIZE_WORD;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'h0000_0000;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'h0000_0000;
          if (datamem_en) begin
            state   <= ST_WAIT;
            cnt     <= CW'(LATENCY - 1);
            rw_q    <= rw;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (commit) begin
            state <= ST_RESP;
            done  <= 1'b1;
            err   <= req_err;
            rdata <= ((rw_q == RW_READ) && !req_err) ? arr_rdata : 32'h0000_0000;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'h0000_0000;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder against a byte-array
// reference model of the memory and its access rules.
module tb_data_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam logic RD = 1'b1, WR = 1'b0, BY = 1'b1, WD = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        datamem_en, rw, size;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mref [DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .datamem_en(datamem_en), .rw(rw), .size(size),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: legality rules and big-endian byte storage.
  task automatic model(input logic r, input logic s, input logic [31:0] a,
                       input logic [31:0] wd, input bit commit,
                       output logic e, output logic [31:0] rd);
    longint unsigned la;
    int unsigned     i;
    la = a;
    if (s == WD) e = (a[1:0] != 2'b00) || (la + 3 >= DEPTH);
    else         e = (la >= DEPTH);
    rd = 32'h0;
    if (!e) begin
      i = a;
      if (r == RD) begin
        if (s == BY) rd = {24'h0, mref[i]};
        else         rd = {mref[i], mref[i+1], mref[i+2], mref[i+3]};
      end else if (commit) begin
        if (s == BY) mref[i] = wd[7:0];
        else begin
          mref[i] = wd[31:24]; mref[i+1] = wd[23:16];
          mref[i+2] = wd[15:8]; mref[i+3] = wd[7:0];
        end
      end
    end
  endtask

  task automatic do_req(input logic r, input logic s, input logic [31:0] a,
                        input logic [31:0] wd, input string tag,
                        output logic [31:0] got_rd, output logic got_err);
    logic        e;
    logic [31:0] ed;
    int          lat;
    model(r, s, a, wd, 1'b1, e, ed);
    @(negedge clk);
    datamem_en = 1'b1; rw = r; size = s; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    datamem_en = 1'b0;
    rw = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
    lat = 0;
    while (!done && lat <= 16) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ".lat"},   lat, LATENCY);
    check({tag, ".busy"},  {31'h0, busy}, 32'h1);
    check({tag, ".err"},   {31'h0, err}, {31'h0, e});
    check({tag, ".rdata"}, rdata, ed);
    got_rd  = rdata;
    got_err = err;
    @(negedge clk);
    check({tag, ".idle"}, {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd, a, exp_rd;
    logic        e, r, s;
    int          cyc, prev, pulses;

    rst_n = 1'b0; datamem_en = 1'b0; rw = 1'b0; size = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    #12;
    check("reset.flags", {29'h0, busy, done, err}, 32'h0);
    check("reset.rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i += 4) do_req(WR, WD, i, $urandom, "fill", rd, e);

    do_req(WR, WD, 32'h10, 32'hDEADBEEF, "t1w", rd, e);
    do_req(RD, WD, 32'h10, 32'h0, "t1r", rd, e);
    check("t1.const", rd, 32'hDEADBEEF);
    do_req(RD, BY, 32'h11, 32'h0, "t2br", rd, e);
    check("t2.byte", rd, 32'h0000_00AD);
    do_req(WR, BY, 32'h12, 32'hFFFFFF55, "t2bw", rd, e);
    do_req(RD, WD, 32'h10, 32'h0, "t2r", rd, e);
    check("t2.merge", rd, 32'hDEAD55EF);

    do_req(RD, WD, 32'h13, 32'h0, "t3mis", rd, e);
    check("t3.mis_err", {31'h0, e}, 32'h1);
    do_req(WR, WD, 32'hFE, 32'hCAFEF00D, "t3oor", rd, e);
    check("t3.oor_err", {31'h0, e}, 32'h1);
    do_req(RD, WD, 32'hFC, 32'h0, "t3fc", rd, e);

    do_req(RD, WD, 32'hFC, 32'h0, "b.fc", rd, e);
    check("b.fc_ok", {31'h0, e}, 32'h0);
    do_req(RD, BY, 32'hFF, 32'h0, "b.ff", rd, e);
    check("b.ff_ok", {31'h0, e}, 32'h0);
    do_req(RD, BY, 32'h100, 32'h0, "b.100", rd, e);
    check("b.100_err", {31'h0, e}, 32'h1);
    do_req(RD, WD, 32'hFFFFFFFC, 32'h0, "b.wrap", rd, e);
    check("b.wrap_err", {31'h0, e}, 32'h1);

    // Back-to-back issue with en held; WAIT-phase inputs are garbage.
    model(RD, WD, 32'h10, 32'h0, 1'b0, e, exp_rd);
    @(negedge clk);
    datamem_en = 1'b1; rw = RD; size = WD; addr = 32'h10;
    cyc = 0; prev = -1; pulses = 0;
    while (pulses < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check("hold.rdata", rdata, exp_rd);
        if (prev >= 0) check("hold.period", cyc - prev, LATENCY + 2);
        prev = cyc;
        pulses++;
        rw = RD; size = WD; addr = 32'h10;
      end else if (busy) begin
        rw = WR; size = $urandom_range(0, 1); addr = $urandom_range(0, 255);
        wdata = $urandom;
      end
    end
    check("hold.pulses", pulses, 3);
    datamem_en = 1'b0;
    @(negedge clk);
    do_req(RD, WD, 32'h10, 32'h0, "hold.after", rd, e);

    // Reset during WAIT abandons the write.
    @(negedge clk);
    datamem_en = 1'b1; rw = WR; size = WD; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    datamem_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst.mid", {30'h0, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(RD, WD, 32'h20, 32'h0, "rst.read", rd, e);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      a = $urandom_range(0, DEPTH + 7);
      if (s == WD && $urandom_range(0, 3) != 0) a = {a[31:2], 2'b00};
      if ($urandom_range(0, 15) == 0) a = 32'hFFFFFFFC;
      do_req(r, s, a, $urandom, "rand", rd, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
